// File: rtl/register_wneg_clkneg_shift_nbit.sv
// WIDTH-bit falling-edge register: active-low parallel load, local shift/rotate modes,
// and a self-sequenced LSB-first serial transfer with Busy/Done status.
module register_wneg_clkneg_shift_nbit #(
  parameter int WIDTH     = 8,
  parameter int SHIFT_LEN = 8
) (
  input  logic             ClkN,
  input  logic             ClrN,
  input  logic             Enbar,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       Mode,
  input  logic             SerIn,
  input  logic             Start,
  output logic [WIDTH-1:0] Q,
  output logic             SerOut,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(SHIFT_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_LEN);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  state_t          state;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;

  assign count_nxt = count + CW'(1);

  // Left shift exits through the MSB; every other mode, and the transfer, exits through the LSB.
  assign SerOut = (state == IDLE && Mode == MODE_SHL) ? Q[WIDTH-1] : Q[0];

  // Start is a level request sampled only in IDLE with Enbar high; there is no
  // ready/ack, so a request held across Done simply starts the next transfer.
  always_ff @(negedge ClkN or negedge ClrN) begin
    if (!ClrN) begin
      state <= IDLE;
      count <= '0;
      Q     <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (!Enbar) begin
            Q <= D;
          end else if (Start) begin
            state <= SHIFT;
            Busy  <= 1'b1;
            count <= '0;
          end else begin
            case (Mode)
              MODE_HOLD: Q <= Q;
              MODE_SHL:  Q <= {Q[WIDTH-2:0], SerIn};
              MODE_SHR:  Q <= {SerIn, Q[WIDTH-1:1]};
              MODE_ROR:  Q <= {Q[0], Q[WIDTH-1:1]};
              default:   Q <= Q;
            endcase
          end
        end
        SHIFT: begin
          Q     <= {SerIn, Q[WIDTH-1:1]};
          count <= count_nxt;
          if (count_nxt == LAST) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_wneg_clkneg_shift_nbit.sv
// Directed bench for register_wneg_clkneg_shift_nbit (WIDTH=8, SHIFT_LEN=8).
// Inputs change 1ns after each falling edge; outputs are checked there too.
module tb_register_wneg_clkneg_shift_nbit;

  logic       ClkN;
  logic       ClrN;
  logic       Enbar;
  logic [7:0] D;
  logic [1:0] Mode;
  logic       SerIn;
  logic       Start;
  logic [7:0] Q;
  logic       SerOut;
  logic       Busy;
  logic       Done;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q;

  register_wneg_clkneg_shift_nbit #(.WIDTH(8), .SHIFT_LEN(8)) dut (
    .ClkN(ClkN), .ClrN(ClrN), .Enbar(Enbar), .D(D), .Mode(Mode), .SerIn(SerIn),
    .Start(Start), .Q(Q), .SerOut(SerOut), .Busy(Busy), .Done(Done)
  );

  initial ClkN = 1'b1;
  always #5 ClkN = ~ClkN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge ClkN);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    Enbar = 1'b0; D = v; Start = 1'b0;
    tick();
    Enbar = 1'b1;
  endtask

  initial begin
    ClrN = 1'b0; Enbar = 1'b1; D = 8'h00; Mode = 2'b00; SerIn = 1'b0; Start = 1'b0;
    #2;
    check("reset_q", Q, 8'h00);
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    @(posedge ClkN); #1;
    ClrN = 1'b1;
    tick();
    check("post_reset_q", Q, 8'h00);

    // Async clear with a transfer in progress
    load(8'hA5);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("pre_clr_busy", Busy, 1'b1);
    check("pre_clr_q", Q, 8'hA5);
    @(posedge ClkN); #1;
    ClrN = 1'b0;
    #1;
    check("async_clr_q", Q, 8'h00);
    check("async_clr_busy", Busy, 1'b0);
    check("async_clr_done", Done, 1'b0);
    Enbar = 1'b0; D = 8'hFF;
    tick();
    check("clr_held_q", Q, 8'h00);
    @(posedge ClkN); #1;
    ClrN = 1'b1;
    #1;
    check("clr_release_q", Q, 8'h00);
    tick();
    check("after_release_load", Q, 8'hFF);
    Enbar = 1'b1;

    // Load and hold
    load(8'h3C);
    check("load_3c", Q, 8'h3C);
    @(posedge ClkN); #1;
    check("rise_no_change", Q, 8'h3C);
    Mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_3c", Q, 8'h3C);
    end
    Enbar = 1'b0; D = 8'h5A; Start = 1'b1;
    tick();
    check("load_beats_start_q", Q, 8'h5A);
    check("load_beats_start_busy", Busy, 1'b0);
    Enbar = 1'b1; Start = 1'b0;
    tick();
    check("start_not_remembered", Busy, 1'b0);

    // Local modes
    load(8'h81);
    Mode = 2'b01; SerIn = 1'b0;
    #1;
    check("shl_serout_msb", SerOut, 1'b1);
    tick();
    check("shl_q", Q, 8'h02);
    check("shl_serout_after", SerOut, 1'b0);
    Mode = 2'b00;
    load(8'h81);
    Mode = 2'b10; SerIn = 1'b1;
    tick();
    check("shr_q", Q, 8'hC0);
    Mode = 2'b00;
    load(8'h81);
    Mode = 2'b11; SerIn = 1'b0;
    tick();
    check("ror_81_q", Q, 8'hC0);
    Mode = 2'b00;
    load(8'h01);
    Mode = 2'b11;
    #1;
    check("ror_serout_lsb", SerOut, 1'b1);
    tick();
    check("ror_01_q", Q, 8'h80);
    Mode = 2'b00;

    // Serial transfer of 0xA5, SerIn=0
    load(8'hA5);
    Start = 1'b1; SerIn = 1'b0;
    tick();
    Start = 1'b0;
    check("xfer_busy", Busy, 1'b1);
    check("xfer_first_bit", SerOut, 1'b1);
    exp_q = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_q = {1'b0, exp_q[7:1]};
      check("xfer_q", Q, exp_q);
      check("xfer_serout", SerOut, exp_q[0]);
      check("xfer_busy_step", Busy, (k < 8) ? 1'b1 : 1'b0);
      check("xfer_done_step", Done, (k == 8) ? 1'b1 : 1'b0);
    end
    check("xfer_final_q", Q, 8'h00);
    tick();
    check("done_one_cycle", Done, 1'b0);

    // Inputs ignored while busy; Start held across Done restarts
    load(8'h96);
    Start = 1'b1; SerIn = 1'b1;
    tick();
    check("busy2_start", Busy, 1'b1);
    exp_q = 8'h96;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        Enbar = 1'b0; D = 8'hFF; Mode = 2'b01;
      end
      if (k == 6) begin
        Enbar = 1'b1; Mode = 2'b00;
      end
      tick();
      exp_q = {1'b1, exp_q[7:1]};
      check("ign_q", Q, exp_q);
      check("ign_serout", SerOut, exp_q[0]);
      check("ign_done", Done, (k == 8) ? 1'b1 : 1'b0);
    end
    check("ign_final_q", Q, 8'hFF);
    tick();
    check("b2b_busy", Busy, 1'b1);
    check("b2b_done_low", Done, 1'b0);
    check("b2b_q_hold", Q, 8'hFF);
    Start = 1'b0; SerIn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("b2b_done", Done, (k == 8) ? 1'b1 : 1'b0);
    end
    check("b2b_final_q", Q, 8'h00);
    tick();

    // Abort mid-transfer, then a clean restart from count 0
    load(8'h0F);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("abort_pre_q", Q, 8'h01);
    @(posedge ClkN); #1;
    ClrN = 1'b0;
    #1;
    check("abort_q", Q, 8'h00);
    check("abort_busy", Busy, 1'b0);
    tick();
    check("abort_no_done", Done, 1'b0);
    @(posedge ClkN); #1;
    ClrN = 1'b1;
    load(8'h0F);
    check("reload_q", Q, 8'h0F);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("restart_busy", Busy, (k < 8) ? 1'b1 : 1'b0);
      check("restart_done", Done, (k == 8) ? 1'b1 : 1'b0);
    end
    check("restart_final_q", Q, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
